// File: rtl/load_store_unit.sv
// RV32I load/store unit over a req/gnt/rvalid port; resp 1 (error), 2 (store), 3 (load) cycles after accept.
// req_ready only while idle; mem_req and its fields hold steady until mem_gnt, aborted after TIMEOUT_CYCLES.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] cnt_q;
  logic        accept, req_bad, timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_data;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign accept      = req_valid & req_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TIMEOUT_CYCLES - 32'd1);

  // Request decode: legality, alignment, byte enables and lane-replicated store data.
  always_comb begin
    req_bad = 1'b0;
    be_d    = 4'b0000;
    wdata_d = 32'd0;
    case (req_funct3)
      3'b000: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        req_bad = req_addr[0] | (req_we & req_funct3[2]);
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        req_bad = |req_addr[1:0];
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
      3'b100:  req_bad = req_we;
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    lb        = mem_rdata[{lane_q, 3'b000} +: 8];
    lh        = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (f3_q)
      3'b000:  load_data = {{24{lb[7]}}, lb};
      3'b100:  load_data = {24'd0, lb};
      3'b001:  load_data = {{16{lh[15]}}, lh};
      3'b101:  load_data = {16'd0, lh};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_bad ? RESP : REQ;
      REQ: begin
        if (mem_gnt)          state_d = we_q ? RESP : WAIT_R;
        else if (timeout_hit) state_d = RESP;
      end
      WAIT_R:  if (mem_rvalid || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      cnt_q      <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q   <= req_we;
          f3_q   <= req_funct3;
          lane_q <= req_addr[1:0];
          cnt_q  <= 32'd0;
          if (req_bad) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= req_we ? be_d : 4'b0000;
            mem_wdata <= req_we ? wdata_d : 32'd0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 32'd1;
          if (mem_gnt || timeout_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
          end
          if (mem_gnt) begin
            if (we_q) begin
              resp_err   <= 1'b0;
              resp_rdata <= 32'd0;
            end
          end else if (timeout_hit) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end
        end
        WAIT_R: begin
          cnt_q <= cnt_q + 32'd1;
          if (mem_rvalid) begin
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end else if (timeout_hit) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end
        end
        RESP:    resp_err <= 1'b0;
        default: resp_err <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-access model of the width/extension rules, a per-cycle monitor,
// and a second instance with a short timeout for the abort path.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        t_req_valid = 1'b0;
  logic        t_req_ready, t_resp_valid, t_resp_err, t_mem_req, t_mem_we;
  logic [31:0] t_resp_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_be;

  int checks = 0, failures = 0, cyc = 0;
  bit in_flight = 1'b0;
  int req_cycles = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  logic        exp_err, exp_we;
  logic [31:0] exp_maddr, exp_wd, exp_rdata;
  logic [3:0]  exp_be;
  int          exp_lat;

  logic [31:0] res_rdata[32];
  logic        res_err[32];
  int          res_lat[32];
  logic [3:0]  res_be[32];
  logic [31:0] res_wd[32];
  int          res_reqc[32];

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut_to (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(t_resp_valid),
    .resp_rdata(t_resp_rdata), .resp_err(t_resp_err), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_be(t_mem_be), .mem_wdata(t_mem_wdata), .mem_gnt(1'b0),
    .mem_rvalid(1'b0), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Access model: size from funct3[1:0], signedness from funct3[2], all in plain arithmetic.
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = 1 << f3[1:0];
    logic illegal = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1:0] == 2'b10));
    return illegal || ((addr % sz) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    longint unsigned v, bits;
    bits = 64'd8 << f3[1:0];
    v = ({32'd0, w} >> (8 * (addr % 4))) & ((64'd1 << bits) - 64'd1);
    if (!f3[2] && bits < 64'd32 && ((v >> (bits - 64'd1)) & 64'd1) == 64'd1) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(!in_flight));
      if (mem_req) begin
        req_cycles++;
        last_be = mem_be;
        last_wd = mem_wdata;
        chk("mem_req_unexpected", 32'(in_flight), 32'd1);
        chk("mem_addr", mem_addr, exp_maddr);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (resp_valid) begin
        chk("resp_unexpected", 32'(in_flight), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
    end
  end

  task automatic run_txn(input int id, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword, input int g, input int r,
                         input bit rst_in_wait);
    int n, reqcyc, wcyc;
    bit granted, done;
    exp_err   = model_err(we, f3, addr);
    exp_we    = we;
    exp_maddr = addr & 32'hFFFF_FFFC;
    exp_be    = (we && !exp_err) ? model_be(f3, addr) : 4'b0000;
    exp_wd    = model_wd(f3, wd);
    exp_rdata = (we || exp_err) ? 32'd0 : model_rdata(f3, addr, rword);
    exp_lat   = exp_err ? 1 : (we ? 2 + g : 3 + g + r);
    @(posedge clk); #1;
    req_cycles = 0; last_be = 4'hF; last_wd = 32'd0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = ~f3; req_addr = ~addr; req_wdata = ~wd;
    in_flight = 1'b1;
    granted = 1'b0; done = 1'b0; reqcyc = 0; wcyc = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      if (mem_req) begin
        mem_rvalid = 1'b1;
        if (reqcyc == g) begin mem_gnt = 1'b1; granted = 1'b1; end
        reqcyc++;
      end else if (granted && !we) begin
        if (rst_in_wait) begin
          in_flight = 1'b0;
          #2 rst = 1'b1;
          #1;
          chk("rst_resp_valid", 32'(resp_valid), 32'd0);
          chk("rst_resp_rdata", resp_rdata, 32'd0);
          chk("rst_resp_err", 32'(resp_err), 32'd0);
          chk("rst_mem_req", 32'(mem_req), 32'd0);
          chk("rst_mem_we", 32'(mem_we), 32'd0);
          chk("rst_mem_be", 32'(mem_be), 32'd0);
          chk("rst_mem_addr", mem_addr, 32'd0);
          chk("rst_mem_wdata", mem_wdata, 32'd0);
          @(posedge clk); #1;
          rst = 1'b0;
          mem_rvalid = 1'b1; mem_rdata = rword;
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          chk("rst_rdata_after", resp_rdata, 32'd0);
          chk("rst_ready_after", 32'(req_ready), 32'd1);
          return;
        end
        if (wcyc == r) begin mem_rvalid = 1'b1; mem_rdata = rword; end
        wcyc++;
      end
      @(negedge clk);
      if (resp_valid) begin
        done = 1'b1;
        res_rdata[id] = resp_rdata;
        res_err[id]   = resp_err;
        res_lat[id]   = cyc - n;
        chk("latency", cyc - n, exp_lat);
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; in_flight = 1'b0;
    chk("resp_seen", 32'(done), 32'd1);
    chk("req_cycles", req_cycles, exp_err ? 0 : g + 1);
    res_be[id] = last_be; res_wd[id] = last_wd; res_reqc[id] = req_cycles;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n, tq;
    bit done;
    #1 rst = 1'b1;
    #2;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_be", 32'(mem_be), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_to_mem_wdata", t_mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    //       id we    f3      addr       wdata         rword         g  r
    run_txn( 0, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF_FF00, 0, 0, 0);
    run_txn( 1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF_FF00, 0, 0, 0);
    run_txn( 2, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0,        0, 0, 0);
    run_txn( 3, 1'b0, 3'b010, 32'h106, 32'h0,        32'h0,         0, 0, 0);
    run_txn( 4, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0,        1, 0, 0);
    run_txn( 5, 1'b0, 3'b001, 32'h102, 32'h0,        32'h8001_7FFF, 0, 0, 0);
    run_txn( 6, 1'b0, 3'b101, 32'h102, 32'h0,        32'h8001_7FFF, 2, 2, 0);
    run_txn( 7, 1'b0, 3'b001, 32'h100, 32'h0,        32'h8001_7FFF, 0, 0, 0);
    run_txn( 8, 1'b0, 3'b000, 32'h101, 32'h0,        32'h1234_5678, 0, 0, 0);
    run_txn( 9, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0,        2, 0, 0);
    run_txn(10, 1'b1, 3'b010, 32'h302, 32'h1111_2222, 32'h0,        0, 0, 0);
    run_txn(11, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,         0, 0, 0);
    run_txn(12, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,         0, 0, 0);
    run_txn(13, 1'b0, 3'b110, 32'h100, 32'h0,        32'h0,         0, 0, 0);
    run_txn(14, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,         0, 0, 0);
    run_txn(15, 1'b0, 3'b101, 32'h103, 32'h0,        32'h0,         0, 0, 0);
    run_txn(16, 1'b1, 3'b001, 32'h200, 32'h0000_5AA5, 32'h0,        0, 0, 0);
    run_txn(17, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEAD_BEEF, 3, 1, 0);
    repeat (3) @(posedge clk);
    #1 chk("rdata_hold", resp_rdata, 32'hDEAD_BEEF);
    run_txn(18, 1'b0, 3'b010, 32'h104, 32'h0,        32'h1111_1111, 0, 5, 1);
    run_txn(19, 1'b0, 3'b010, 32'h104, 32'h0,        32'h0BAD_F00D, 0, 0, 0);

    chk("lit_lb_rdata", res_rdata[0], 32'hFFFF_FF80);
    chk("lit_lb_be", 32'(res_be[0]), 32'h0);
    chk("lit_lbu_rdata", res_rdata[1], 32'h0000_0080);
    chk("lit_sh_be", 32'(res_be[2]), 32'hC);
    chk("lit_sh_wdata", res_wd[2], 32'hABCD_ABCD);
    chk("lit_sh_lat", res_lat[2], 32'd2);
    chk("lit_sh_err", 32'(res_err[2]), 32'd0);
    chk("lit_lw_mis_err", 32'(res_err[3]), 32'd1);
    chk("lit_lw_mis_lat", res_lat[3], 32'd1);
    chk("lit_lw_mis_reqc", res_reqc[3], 32'd0);
    chk("lit_sb_be", 32'(res_be[4]), 32'h2);
    chk("lit_sb_wdata", res_wd[4], 32'hA5A5_A5A5);
    chk("lit_lh_rdata", res_rdata[5], 32'hFFFF_8001);
    chk("lit_lhu_rdata", res_rdata[6], 32'h0000_8001);
    chk("lit_lb1_rdata", res_rdata[8], 32'h0000_0056);
    chk("lit_sh0_be", 32'(res_be[16]), 32'h3);
    chk("lit_sh0_wdata", res_wd[16], 32'h5AA5_5AA5);
    chk("lit_lw_wait_rdata", res_rdata[17], 32'hDEAD_BEEF);
    chk("lit_lw_wait_reqc", res_reqc[17], 32'd4);
    chk("lit_lw_wait_lat", res_lat[17], 32'd7);
    chk("lit_lw_after_rst", res_rdata[19], 32'h0BAD_F00D);
    chk("lit_lw_after_rst_lat", res_lat[19], 32'd3);

    // Abort path on the short-timeout instance: memory never grants.
    @(posedge clk); #1;
    chk("to_ready", 32'(t_req_ready), 32'd1);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'd0;
    t_req_valid = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    tq = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (t_mem_req) begin
        tq++;
        chk("to_mem_addr", t_mem_addr, 32'h100);
        chk("to_mem_be", 32'(t_mem_be), 32'd0);
        chk("to_mem_we", 32'(t_mem_we), 32'd0);
      end
      if (t_resp_valid) begin
        done = 1'b1;
        chk("to_lat", cyc - n, 1 + TO);
        chk("to_err", 32'(t_resp_err), 32'd1);
        chk("to_rdata", t_resp_rdata, 32'd0);
        chk("to_mem_req_low", 32'(t_mem_req), 32'd0);
      end
    end
    chk("to_resp_seen", 32'(done), 32'd1);
    chk("to_req_cycles", tq, TO);
    @(posedge clk); #1;
    chk("to_ready_after", 32'(t_req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
